// File: rtl/key_scanner_pkg.sv
// key_scanner_pkg: FSM states, keypad key codes and board defaults for the keypad scanner
package key_scanner_pkg;
  typedef enum logic [1:0] {KS_SCAN, KS_DEB_PRESS, KS_PRESSED, KS_DEB_REL} ks_state_t;
  localparam int KS_SCAN_DIV_DEFAULT = 50000;
  localparam logic [3:0] KEY_1 = 4'd0;
  localparam logic [3:0] KEY_2 = 4'd1;
  localparam logic [3:0] KEY_3 = 4'd2;
  localparam logic [3:0] KEY_MODE = 4'd3;
  localparam logic [3:0] KEY_4 = 4'd4;
  localparam logic [3:0] KEY_5 = 4'd5;
  localparam logic [3:0] KEY_6 = 4'd6;
  localparam logic [3:0] KEY_PREV = 4'd7;
  localparam logic [3:0] KEY_7 = 4'd8;
  localparam logic [3:0] KEY_8 = 4'd9;
  localparam logic [3:0] KEY_9 = 4'd10;
  localparam logic [3:0] KEY_NEXT = 4'd11;
  localparam logic [3:0] KEY_BACK = 4'd12;
  localparam logic [3:0] KEY_0 = 4'd13;
  localparam logic [3:0] KEY_STOP = 4'd14;
  localparam logic [3:0] KEY_CONFIRM = 4'd15;
  // lowest asserted (low) row wins when several keys share a column
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    return !rows[0] ? 2'd0 : !rows[1] ? 2'd1 : !rows[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/key_sync.sv
// key_sync: two-flop synchronizer for the active-low keypad row lines
module key_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);
  logic [3:0] meta;
  // rows reset to idle (all high) so nothing looks pressed out of reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= '1;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/key_scanner.sv
// key_scanner: 4x4 keypad column scanner with press/release debounce; KEY_REPEAT_EN adds auto-repeat
module key_scanner
  import key_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = KS_SCAN_DIV_DEFAULT,
  parameter int DEBOUNCE_SCANS = 10,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = DEBOUNCE_SCANS > 1 ? $clog2(DEBOUNCE_SCANS) : 1;
  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_params
    $error("key_scanner: invalid parameters");
  end
  logic [3:0] row_s, pat;
  logic [DIV_W-1:0] slot;
  logic [DEB_W-1:0] deb;
  logic [1:0] col, row;
  ks_state_t state;
  logic sample, deb_last, row_up, accept, done_rel, rep_hit;
  key_sync u_sync (.clk(clk), .rst_n(rst_n), .d(row_in), .q(row_s));
  assign sample = slot == DIV_W'(SCAN_DIV - 1);
  assign deb_last = deb == DEB_W'(DEBOUNCE_SCANS - 1);
  assign row_up = row_s[row];
  assign col_out = ~(4'b0001 << col);
  // deb holds one less than the matching-sample count, so the final match triggers the transition
  assign accept = sample && deb_last && ((state == KS_SCAN && row_s != 4'hF) || (state == KS_DEB_PRESS && row_s == pat));
  assign done_rel = sample && deb_last && row_up && (state == KS_PRESSED || state == KS_DEB_REL);
`ifdef KEY_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DELAY + 1);
  logic [REP_W-1:0] rep;
  logic rep_step;
  assign rep_step = sample && state == KS_PRESSED && !row_up;
  assign rep_hit = rep_step && rep + 1'b1 == REP_W'(REPEAT_DELAY);
  // counts held samples; after the first repeat it restarts REPEAT_RATE short of the delay
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rep <= '0;
    else if (accept) rep <= '0;
    else if (rep_step) rep <= rep_hit ? REP_W'(REPEAT_DELAY - REPEAT_RATE) : rep + 1'b1;
`else
  assign rep_hit = 1'b0;
`endif
  // free-running slot counter; its last cycle is the row sample point
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) slot <= '0;
    else slot <= sample ? '0 : slot + 1'b1;
  // scan/debounce FSM; accept and release override the per-state updates
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= KS_SCAN;
      col <= '0;
      row <= '0;
      pat <= 4'hF;
      deb <= '0;
      key_code <= '0;
      key_valid <= 1'b0;
      key_held <= 1'b0;
    end else begin
      key_valid <= accept | rep_hit;
      if (sample)
        case (state)
          KS_SCAN: begin
            row <= low_row(row_s);
            pat <= row_s;
            if (row_s == 4'hF) col <= col + 2'd1;
            else begin
              state <= KS_DEB_PRESS;
              deb <= DEB_W'(1);
            end
          end
          KS_DEB_PRESS:
            if (row_s != pat) begin
              state <= KS_SCAN;
              col <= col + 2'd1;
              deb <= '0;
            end else deb <= deb + 1'b1;
          KS_PRESSED:
            if (row_up) begin
              state <= KS_DEB_REL;
              deb <= DEB_W'(1);
            end
          KS_DEB_REL:
            if (!row_up) begin
              state <= KS_PRESSED;
              deb <= '0;
            end else deb <= deb + 1'b1;
        endcase
      if (accept) begin
        state <= KS_PRESSED;
        deb <= '0;
        key_code <= {low_row(row_s), col};
        key_held <= 1'b1;
      end
      if (done_rel) begin
        state <= KS_SCAN;
        deb <= '0;
        col <= col + 2'd1;
        key_held <= 1'b0;
      end
    end
endmodule
